// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the four-way MUX_2 select path.
// Produces a registered one-hot grant plus the matching mux select/enable,
// with grant tenure bounded by MAX_HOLD whenever another requester waits.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] S,
    output logic       EN,
    output logic [3:0] HOLD
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] s_q, s_d;
    logic       en_q, en_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [3:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;

    // Round-robin search: scans after+1, after+2, after+3, after (mod 4).
    // Returns {found, index}; the earliest set bit in scan order wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] after);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk the scan order backwards so the earliest hit is assigned last.
        for (int k = 4; k >= 1; k--) begin
            idx = after + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state and next-output computation for the arbiter.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        s_d      = s_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        others   = REQ & ~(4'b0001 << s_q);
        pick_all = rr_pick(REQ, last_q);
        pick_oth = rr_pick(others, s_q);

        case (state_q)
            ST_IDLE: begin
                if (pick_all[2]) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << pick_all[1:0];
                    s_d     = pick_all[1:0];
                    en_d    = 1'b1;
                    cnt_d   = 4'd1;
                    last_d  = pick_all[1:0];
                end
            end
            ST_GRANT: begin
                if (!REQ[s_q] || (cnt_q == MAX_HOLD_C && others != 4'b0000)) begin
                    // Release or pre-empt: hand over in one edge, else go idle.
                    if (pick_oth[2]) begin
                        gnt_d  = 4'b0001 << pick_oth[1:0];
                        s_d    = pick_oth[1:0];
                        en_d   = 1'b1;
                        cnt_d  = 4'd1;
                        last_d = pick_oth[1:0];
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        s_d     = 2'b00;
                        en_d    = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end else if (cnt_q != MAX_HOLD_C) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                s_d     = 2'b00;
                en_d    = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and registered outputs; reset restarts the search at requester 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            s_q     <= 2'b00;
            en_q    <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign GNT  = gnt_q;
    assign S    = s_q;
    assign EN   = en_q;
    assign HOLD = cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed stimulus pushes the
// hand-computed post-edge outputs; a monitor pops and compares each cycle.
module tb_mux_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] S;
    logic       EN;
    logic [3:0] HOLD;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       en;
        logic [3:0] hold;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .GNT (GNT),
        .S   (S),
        .EN  (EN),
        .HOLD(HOLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of stimulus and record what the next edge must produce.
    task automatic step(input logic rst, input logic [3:0] req,
                        input logic [3:0] g, input logic [1:0] s,
                        input logic [3:0] h, input string name);
        exp_t e;
        @(negedge CLK);
        RST = rst;
        REQ = req;
        e.gnt  = g;
        e.s    = s;
        e.en   = (g != 4'b0000);
        e.hold = h;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: after every edge, compare outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (GNT !== e.gnt || S !== e.s || EN !== e.en || HOLD !== e.hold) begin
                    errors++;
                    $display("FAIL %s: got GNT=%b S=%0d EN=%b HOLD=%0d, want GNT=%b S=%0d EN=%b HOLD=%0d",
                             e.name, GNT, S, EN, HOLD, e.gnt, e.s, e.en, e.hold);
                end
                checks++;
                if (EN !== (GNT != 4'b0000) || !$onehot0(GNT) ||
                    (EN && GNT !== (4'b0001 << S))) begin
                    errors++;
                    $display("FAIL invariant_%s: got GNT=%b S=%0d EN=%b, want one-hot GNT matching S and EN", 
                             e.name, GNT, S, EN);
                end
            end
        end
    end

    initial begin
        int n;
        RST = 1'b1;
        REQ = 4'b0000;

        // Reset held with all requests asserted.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, 2'd0, 4'd0, "reset");
        step(1'b0, 4'b1111, 4'b0001, 2'd0, 4'd1, "reset_release");

        // Rotation: owner 0 finishes its tenure, then 1,2,3 get 4 cycles, then 0.
        for (int h = 2; h <= 4; h++) step(1'b0, 4'b1111, 4'b0001, 2'd0, 4'(h), "rot_owner0");
        for (int o = 1; o <= 3; o++)
            for (int h = 1; h <= 4; h++)
                step(1'b0, 4'b1111, 4'b0001 << o, 2'(o), 4'(h), "rotation");
        step(1'b0, 4'b1111, 4'b0001, 2'd0, 4'd1, "rot_wrap");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 4'd0, "rot_idle");

        // Single requester 2: hold counts up then saturates at 4.
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 4'd1, "single_h1");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 4'd2, "single_h2");
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 4'd3, "single_h3");
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0100, 4'b0100, 2'd2, 4'd4, "single_sat");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 4'd0, "single_drop");

        // Early release of owner 3 wraps to requester 0 with no idle cycle.
        step(1'b0, 4'b1000, 4'b1000, 2'd3, 4'd1, "wrap_own3");
        step(1'b0, 4'b1001, 4'b1000, 2'd3, 4'd2, "wrap_keep3");
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 4'd1, "wrap_to0");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 4'd0, "wrap_idle");

        // Owner 1 alone for 8 cycles, then a late request from 3 pre-empts.
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 4'd1, "late_h1");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 4'd2, "late_h2");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 4'd3, "late_h3");
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, 4'b0010, 2'd1, 4'd4, "late_sat");
        step(1'b0, 4'b1010, 4'b1000, 2'd3, 4'd1, "late_preempt");
        step(1'b0, 4'b1010, 4'b1000, 2'd3, 4'd2, "late_keep3");
        step(1'b0, 4'b0010, 4'b0010, 2'd1, 4'd1, "late_back1");

        // Reset mid-grant, then arbitration restarts from requester 0.
        step(1'b1, 4'b0010, 4'b0000, 2'd0, 4'd0, "midreset");
        step(1'b0, 4'b0110, 4'b0010, 2'd1, 4'd1, "midreset_resume");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 4'd0, "final_idle");

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge CLK);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4-input select path of MUX_2 between four requesters. It samples a 4-bit request vector every clock and produces a registered one-hot grant. It drives the mux select `S[1:0]` and enable `EN` directly, so exactly one requester owns the mux at a time. Grant tenure is bounded by a hold counter, so no requester can starve the others.

## Interface
- `MAX_HOLD`, 4, maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..15.
- `CLK`  input  1  system clock; all state updates on rising edge.
- `RST`  input  1  synchronous, active-high reset; sampled on rising edge of `CLK`.
- `REQ`  input  4  request vector; bit i high = requester i wants the mux; level-sensitive.
- `GNT`  output  4  registered one-hot grant; all-zero when idle.
- `S`  output  2  mux select = index of granted requester; drives MUX_2 `S`.
- `EN`  output  1  mux enable; high exactly when `GNT` is non-zero; drives MUX_2 `EN`.
- `HOLD`  output  4  current tenure count of the granted requester, for debug; 0 when idle.

## Operation
- **State.**
  - FSM states: IDLE, GRANT.
  - Round-robin pointer `LAST[1:0]` holds the index of the most recently granted requester.
  - Hold counter `CNT[3:0]` counts the current grant's tenure.
- **Reset values.** `RST`=1 at an edge forces:
  - state=IDLE
  - `GNT`=4'b0000, `S`=2'b00, `EN`=0, `HOLD`=0
  - `LAST`=2'b11, so the first search starts at requester 0.
- **Priority search.**
  - Starts at the index after a given one and scans (i+1)%4, (i+2)%4, (i+3)%4, i.
  - The first set bit wins.
  - Wrap-around from 3 to 0 is mandatory.
- **IDLE.**
  - `REQ`=0: remain in IDLE; outputs stay zero.
  - `REQ`≠0: search starting at `LAST`+1. At the next edge, winner w gets:
    - `GNT`=1<<w, `S`=w, `EN`=1
    - `LAST`=w, `CNT`=1
    - state GRANT
- **GRANT, current owner c=`S`.**
  - **Release.** `REQ[c]`=0:
    - Search the other three, starting at c+1.
    - If a winner w exists: grant w at the next edge (`CNT`=1, `LAST`=w); there is no idle bubble.
    - Otherwise: go to IDLE and clear `GNT`/`EN`/`S`/`HOLD` to zero.
  - **Pre-empt.** `REQ[c]`=1, `CNT`==`MAX_HOLD`, and another request pending:
    - Grant the next requester found by the search from c+1.
    - `CNT`=1.
  - **Continue.** `REQ[c]`=1 otherwise:
    - Keep the grant.
    - `CNT` increments, saturating at `MAX_HOLD`.
    - A lone owner therefore holds the grant indefinitely, and a late-arriving request pre-empts it on the first edge it is seen.
- **Invariants.**
  - `GNT` is always one-hot or zero.
  - `EN` == |`GNT`.
  - `S` is consistent with `GNT` whenever `EN`=1.
  - `HOLD` == `CNT` in GRANT.
- Requests from non-owners are never latched; dropping `REQ` before it is granted withdraws it.

## Timing
- All outputs are registered; there is no combinational path from `REQ` to `GNT`/`S`/`EN`.
- **Request latency.** 1 cycle from `REQ` sampled high in IDLE to `GNT`/`EN` high.
- **Release latency.** Owner drops `REQ` in cycle n → `GNT` changes (to the next owner or zero) at the edge ending cycle n.
- **Hand-over.** A switch between owners happens in a single edge; `EN` stays high with no gap.
- **Maximum wait.** A continuously asserting requester is granted within 3·`MAX_HOLD`+1 cycles.
- **Simultaneous events.**
  - Reset has priority over everything.
  - Release and pre-empt in the same cycle are treated as release.
  - Pre-emption never re-grants the current owner in the same edge when another requester is pending.
- **Reset mid-grant.** The next edge clears all outputs, even with `REQ` held. Arbitration resumes one cycle after `RST` falls, starting from requester 0.

## Test plan
- **Reset.** Hold `RST`=1 for 3 cycles with `REQ`=4'b1111 → `GNT`=0, `EN`=0, `S`=0, `HOLD`=0. Release `RST` → next edge `GNT`=4'b0001, `S`=0.
- **Single requester.** `REQ`=4'b0100 held for 10 cycles → `GNT`=4'b0100 and `S`=2 from cycle 1. `HOLD` counts 1,2,3,4 then saturates at 4. `REQ` dropped → `GNT`=0 at the next edge.
- **Rotation.** `REQ`=4'b1111 constant, `MAX_HOLD`=4 → grant order 0,1,2,3,0; each grant lasts exactly 4 cycles. `EN` stays high continuously with no gap.
- **Early release with wrap-around.**
  - With `LAST`=3 and owner 3 granted, `REQ` goes 4'b1001 → 4'b0001.
  - Required: `GNT`=4'b0001 at the next edge, with no IDLE cycle.
- **Late pre-emption.**
  - Owner 1 alone for 8 cycles, then `REQ`=4'b1010 → at the next edge `GNT`=4'b1000, `S`=3, `HOLD`=1.
- **Reset mid-grant.** Pulse `RST` for 1 cycle while `GNT`=4'b0010 → `GNT`=0 next edge. The following edge grants the lowest set `REQ` bit, searching from 0.
